frame_fifo_resp: RTL
====================

Name: frame_fifo_resp

Overview:
- Per-channel input frame buffer; responder side of the noise-cancelling controller's FFT-start handshake.
- Collects windowed samples written on wr_ce into ping-pong frame banks and raises ready when a full frame is held.
- On a single-cycle start_fft pulse, streams the frame to the FFT, one sample per cycle.
- c1a/c1b/c2a/c2b are all instances of this block; the b instances use OFFSET=64 to give 50% frame overlap.

Parameters:
- DATA_W, 16, sample width.
- FRAME_LEN, 128, samples per frame; power of two, >= 4.
- OFFSET, 0, number of samples discarded after reset before the first frame starts. Use 64 for the b channels. Must be < FRAME_LEN.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- wr_ce  in  1  write strobe, one sample per high cycle.
- din  in  DATA_W  sample written when wr_ce=1.
- start_fft  in  1  single-cycle read request from the controller.
- ready  out  1  level; high while a full bank is waiting and no read is in progress.
- dout  out  DATA_W  registered read data.
- dout_valid  out  1  high for exactly FRAME_LEN consecutive cycles per accepted read.
- frame_last  out  1  high together with the last dout_valid cycle.
- overflow  out  1  sticky; set when a sample is dropped, cleared only by reset.
- hn_index  out  clog2(FRAME_LEN)  read-side sample index (see Optional Feature).

Behaviour:
- Reset, asynchronous while n_rst=0:
  - outputs: ready, dout, dout_valid, frame_last, overflow and hn_index all 0.
  - internal state: both banks empty, write bank = 0, write pointer = 0, skip counter = OFFSET, read FSM = IDLE.
- Reset asserted mid-read or mid-fill aborts the operation immediately. No partial frame survives reset.
- Skip phase:
  - While the skip counter is nonzero, each wr_ce decrements it and the sample is discarded.
  - ready stays 0 during the skip phase.
- Write side:
  - Each wr_ce writes din to wbank[wptr], then wptr increments.
  - When wptr wraps from FRAME_LEN-1 to 0, the bank is marked full and the write bank toggles.
  - If the target bank is already full (both banks full), the sample is dropped, wptr does not advance, and overflow is set.
- Read FSM, states IDLE and READ:
  - IDLE: ready = (any bank full). If start_fft=1 and ready=1, latch the oldest full bank, rptr=0, go to READ. ready falls the following cycle.
  - start_fft while ready=0 is ignored: no state change, no error.
  - READ:
    - First dout_valid occurs the cycle after the accepting start_fft. Latency is 1 cycle.
    - dout = rbank[rptr], one sample per cycle, with no stalls.
    - frame_last coincides with rptr=FRAME_LEN-1.
    - The cycle after frame_last, the bank is marked empty and the FSM returns to IDLE.
    - ready may rise again on that same cycle if the other bank is full.
  - start_fft during READ is ignored.
- Ordering: banks are always read in fill order (oldest first).
- Simultaneous events:
  - A write completing bank X in the same cycle the read of bank Y ends: both bank-flag updates take effect together.
  - The free/full flag update is an atomic per-bank flag update, with no lost frame.
  - A write to the bank currently being read cannot occur, because that bank is full until freed.
- Arithmetic: pointers count modulo FRAME_LEN with natural binary wrap. The data path is a pure copy; no arithmetic is applied to samples.
- dout holds its last value when dout_valid=0.

Optional Feature:
- Macro HANN_INDEX_EN.
- Defined: hn_index outputs rptr registered alongside dout. It is valid when dout_valid=1 and holds 0 otherwise, so a downstream synthesis window can be indexed per sample.
- Not defined: hn_index is tied to 0 and no index register is built. All other behaviour is identical.

Test Plan:
- OFFSET=0: write 128 samples 0..127 on consecutive cycles -> ready=1 the cycle after the 128th write. start_fft -> dout 0..127 on 128 cycles, frame_last on value 127, ready=0 during read.
- OFFSET=64: write 0..191 -> first 64 discarded, ready rises after sample 191, streamed frame is 64..191.
- Write 256 samples with no start_fft -> both banks full. Sample 257 is dropped and overflow=1. start_fft -> 0..127, then ready remains 1 and a second start_fft yields 128..255.
- start_fft while empty, and a second start_fft mid-read -> ignored, exactly 128 dout_valid cycles total.
- n_rst pulsed low at read cycle 40 -> all outputs 0 immediately. After release, 128 new writes are needed before ready.
- With HANN_INDEX_EN: hn_index runs 0..127 aligned with dout_valid. Without: hn_index stays 0 throughout.

Source files
------------

// File: rtl/frame_fifo_resp.sv
// frame_fifo_resp: per-channel ping-pong frame buffer, responder side of
// the FFT-start handshake. Samples written on wr_ce fill two frame banks
// alternately; a start_fft pulse streams the oldest full bank out one
// sample per cycle.
//
// Optional build macro: HANN_INDEX_EN
//   defined     -> hn_index carries the in-frame index of each dout sample
//   not defined -> hn_index is tied to 0 and no index register exists
module frame_fifo_resp #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 128,
  parameter int OFFSET    = 0,
  localparam int PTR_W    = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_ce,
  input  logic [DATA_W-1:0] din,
  input  logic              start_fft,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_last,
  output logic              overflow,
  output logic [PTR_W-1:0]  hn_index
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, READ} state_t;

  // Both banks live in one array; the bank number is the address MSB.
  logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

  state_t            state, state_nxt;
  logic [1:0]        full, full_nxt;
  logic              wbank;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  skip_cnt;
  logic              rd_next;   // oldest full bank, next one to be read
  logic              rbank;
  logic [PTR_W-1:0]  rptr;      // index of the sample currently on dout
  logic [PTR_W-1:0]  rptr_inc;

  logic              wr_live;
  logic              wr_accept;
  logic              wr_wrap;
  logic              rd_accept;
  logic              rd_end;
  logic [PTR_W:0]    rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Handshake decode, next bank flags and next read address.
  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    wr_live   = wr_ce && (skip_cnt == '0);
    wr_accept = wr_live && !full[wbank];
    wr_wrap   = wr_accept && (wptr == LAST_IDX);
    rd_accept = (state == IDLE) && start_fft && ready;
    rd_end    = (state == READ) && (rptr == LAST_IDX);
    rptr_inc  = rptr + PTR_W'(1);

    // The bank being read stays full until freed, so a write never
    // completes that same bank; both flag updates can land together.
    full_nxt = full;
    if (wr_wrap) full_nxt[wbank] = 1'b1;
    if (rd_end)  full_nxt[rbank] = 1'b0;

    state_nxt = state;
    if (rd_accept)   state_nxt = READ;
    else if (rd_end) state_nxt = IDLE;

    rd_addr = rd_accept ? {rd_next, {PTR_W{1'b0}}} : {rbank, rptr_inc};
    rd_data = mem[rd_addr];
  end

  // Sample storage write port.
  // NOTE: the frame memory has no reset; the full flags alone decide whether its contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[{wbank, wptr}] <= din;
  end

  // Write pointer, skip counter, bank flags and the read FSM with its registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      full       <= '0;
      wbank      <= 1'b0;
      wptr       <= '0;
      skip_cnt   <= PTR_W'(OFFSET);
      rd_next    <= 1'b0;
      rbank      <= 1'b0;
      rptr       <= '0;
      ready      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_last <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      ready <= (state_nxt == IDLE) && (|full_nxt);

      if (wr_ce && (skip_cnt != '0)) skip_cnt <= skip_cnt - PTR_W'(1);
      if (wr_live && full[wbank])    overflow <= 1'b1;

      if (wr_accept) begin
        wptr <= wptr + PTR_W'(1);
        if (wr_wrap) wbank <= ~wbank;
      end

      case (state)
        IDLE: begin
          if (rd_accept) begin
            rbank      <= rd_next;
            rptr       <= '0;
            dout       <= rd_data;
            dout_valid <= 1'b1;
            frame_last <= 1'b0;
          end
        end
        READ: begin
          if (rd_end) begin
            dout_valid <= 1'b0;
            frame_last <= 1'b0;
            rd_next    <= ~rd_next;
          end else begin
            rptr       <= rptr_inc;
            dout       <= rd_data;
            frame_last <= (rptr_inc == LAST_IDX);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HANN_INDEX_EN
  // In-frame index registered alongside dout; 0 whenever dout is not valid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hn_index <= '0;
    end else if (rd_accept) begin
      hn_index <= '0;
    end else if ((state == READ) && !rd_end) begin
      hn_index <= rptr_inc;
    end else begin
      hn_index <= '0;
    end
  end
`else
  assign hn_index = '0;
`endif

endmodule
